lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store initiator between the core's execute stage and the byte-enabled data memory (combinational read, synchronous write, 1024 bytes).
- Accepts one load/store request at a time and steers bytes/halfwords/words onto the memory lanes.
- Generates word-aligned addresses, byte enables and shifted write data; sign/zero-extends load data.
- Returns a registered response with a valid/ready handshake, or a fault for illegal, misaligned or out-of-range accesses.

Parameters:
- MEM_BYTES, 1024: memory size in bytes. Any access touching a byte at or above MEM_BYTES faults.
- ADDR_W, 32: request and memory address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when valid&&ready
- resp_rdata  out  32  extended load data (0 for stores/faults)
- resp_fault  out  1  access not performed
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits always 0)
- mem_wdata  out  32  lane-shifted write data
- mem_byte_enable  out  4  lane enables
- mem_rdata  in  32  memory read word (combinational, valid when mem_write=0)

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high.
- States: IDLE, ACC0, ACC1, RESP.
- Reset values:
  - state=IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_fault=0.
  - mem_write=0, mem_addr=0, mem_wdata=0, mem_byte_enable=0.
- req_ready = (state==IDLE) && !rst.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Request capture: on accept, the request is registered. Then:
  - Illegal, out-of-range or (feature off) misaligned: go IDLE→RESP with resp_fault=1. No memory cycle occurs.
  - Otherwise: go IDLE→ACC0.
- Lane mapping:
  - off = addr[1:0]; size mask = 0001, 0011 or 1111.
  - be64 = mask<<off.
  - wd64 = wdata<<(8*off).
- ACC0:
  - mem_addr = addr & ~3.
  - mem_byte_enable = be64[3:0].
  - mem_wdata = wd64[31:0].
  - mem_write = is_store.
  - Loads latch mem_rdata at the end of ACC0.
  - If be64[7:4]≠0, go to ACC1; else go to RESP.
- ACC1:
  - mem_addr = (addr & ~3)+4.
  - mem_byte_enable = be64[7:4].
  - mem_wdata = wd64[63:32].
  - Loads latch the upper word.
  - Go to RESP.
- Outside ACC0/ACC1: all mem_* outputs are 0.
- Load data: assembled 64-bit {hi,lo} >> (8*off), truncated to size, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
- RESP: resp_valid=1, outputs held stable until resp_ready.
  - On handshake go to IDLE.
  - No new request is accepted in RESP, so there is one outstanding access maximum.
- Latency:
  - Aligned: accept edge → resp_valid 2 cycles later.
  - Split: 3 cycles.
  - Fault: 1 cycle.
- Boundaries:
  - Range check uses the highest touched byte: addr+size−1 ≥ MEM_BYTES faults. Address wrap past 2^ADDR_W also faults.
  - A store to the last word (addr=1020, SW) is legal.
  - A split store writes both words on consecutive edges. A fault prevents both writes; there is never a partial write.
- Reset mid-operation:
  - mem_write is gated by !rst, so an asserted rst in ACC0/ACC1 suppresses that cycle's write.
  - State returns to IDLE and any pending response is dropped.
- req_valid while not ready is ignored. The requester must hold the request.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned halfword/word accesses are split into ACC0+ACC1 as above.
- Undefined: any access with addr not size-aligned faults with no memory cycle. ACC1 and the 64-bit upper lanes are not compiled.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Enum lsu_state_t {IDLE, ACC0, ACC1, RESP}.
  - Function size_mask(funct3).
- Sub-module lsu_align: purely combinational.
  - Store direction: lane steering (be64, wd64).
  - Load direction: extraction/extension.
  - The FSM, capture registers and range check stay in lsu_ctrl.

Test Plan:
- Reset: assert rst 2 cycles → req_ready=1, resp_valid=0, mem_write=0, mem_byte_enable=0.
- SW then LW: SW addr=0x10, wdata=0xDEADBEEF → ACC0 drives mem_addr=0x10, be=1111, mem_write=1. LW addr=0x10 → resp_rdata=0xDEADBEEF two cycles after accept.
- SB and sign extension:
  - SB addr=0x23, wdata=0x80 → mem_addr=0x20, be=1000, mem_wdata=0x80000000.
  - LB addr=0x23 → resp_rdata=0xFFFFFF80.
  - LBU addr=0x23 → resp_rdata=0x00000080.
- Misaligned (feature on): SW addr=0x42, wdata=0x11223344 → ACC0 at 0x40 with be=1100, mem_wdata=0x33440000; ACC1 at 0x44 with be=0011, mem_wdata=0x00001122. LW addr=0x42 → 0x11223344.
- Misaligned (feature off): same SW → resp_fault=1 one cycle after accept, and no mem_write pulse.
- Faults and reset:
  - LW addr=1022 → fault.
  - funct3=011 → fault.
  - rst asserted during ACC0 of an SW → no write (read-back returns the old value), state returns to IDLE.
  - Holding resp_ready=0 for 3 cycles keeps resp_valid and resp_rdata stable and req_ready=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RV32I funct3 width codes, the
// controller state encoding, the lane-span width and small decode helpers.
//
// Build option: LSU_MISALIGN_SPLIT_EN
//   defined   -> misaligned halfword/word accesses are split over two memory
//                words, so the lane datapath spans 8 bytes.
//   undefined -> misaligned accesses fault, so the lane datapath spans 4 bytes.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // RV32I load/store width codes (stores use only B/H/W).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Number of byte lanes the steering logic covers. A split access touches
    // two adjacent memory words, which needs an 8-byte span.
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int SPAN_BYTES = 8;
`else
    localparam int SPAN_BYTES = 4;
`endif
    localparam int SPAN_W = 8 * SPAN_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Byte-lane mask for an access starting at lane 0.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_mask = 4'b0001;
            F3_H, F3_HU: size_mask = 4'b0011;
            F3_W:        size_mask = 4'b1111;
            default:     size_mask = 4'b0000;
        endcase
    endfunction

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic funct3_legal(input logic is_store,
                                          input logic [2:0] funct3);
        if (is_store)
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            funct3_legal = (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the load/store unit.
//   Store direction: builds the lane enables and lane-shifted write data over
//   the SPAN_BYTES-wide window starting at the word-aligned base address.
//   Load direction: shifts the assembled read span down by the byte offset,
//   truncates to the access size and sign/zero-extends to 32 bits.
//
// Ports:
//   i_off         byte offset of the access inside its first word
//   i_funct3      RV32I width/sign code
//   i_wdata       right-justified store data
//   i_rdata_span  read data, {upper word, lower word} when the span is 8 bytes
//   o_be_span     lane enables across the span
//   o_wd_span     lane-shifted write data across the span
//   o_load_data   extended load result
//
// Build option: LSU_MISALIGN_SPLIT_EN (selects the span width via lsu_pkg).
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]            i_off,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_wdata,
    input  logic [SPAN_W-1:0]     i_rdata_span,
    output logic [SPAN_BYTES-1:0] o_be_span,
    output logic [SPAN_W-1:0]     o_wd_span,
    output logic [31:0]           o_load_data
);

    logic [3:0]  w_mask;
    logic [31:0] w_word;

    always_comb begin
        w_mask    = size_mask(i_funct3);
        o_be_span = SPAN_BYTES'(w_mask) << i_off;
        o_wd_span = SPAN_W'(i_wdata) << {i_off, 3'b000};
    end

    // Bring the addressed byte down to lane 0; anything above the access size
    // is discarded by the extension below.
    always_comb begin
        w_word = 32'(i_rdata_span >> {i_off, 3'b000});
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_word[7]}}, w_word[7:0]};
            F3_H:    o_load_data = {{16{w_word[15]}}, w_word[15:0]};
            F3_W:    o_load_data = w_word;
            F3_BU:   o_load_data = {24'd0, w_word[7:0]};
            F3_HU:   o_load_data = {16'd0, w_word[15:0]};
            default: o_load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store initiator between the execute stage and a byte-enabled data
// memory (combinational read, synchronous write). One request is held at a
// time: it is captured on accept, checked (funct3 legality, range, alignment),
// performed in one or two word cycles, and answered with a registered
// response held until the consumer takes it.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/ready   request handshake; ready only in IDLE
//   req_is_store      1 = store, 0 = load
//   req_funct3        RV32I width/sign code
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data (0 for stores and faults)
//   resp_fault        access was not performed
//   mem_write         write strobe (suppressed while rst is high)
//   mem_addr          word-aligned memory address
//   mem_wdata         lane-shifted write data
//   mem_byte_enable   lane enables
//   mem_rdata         combinational read word for mem_addr
//
// Build option: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned halfword and
// word accesses are split across two words (ACC0 then ACC1); when undefined
// they fault and the ACC1 datapath is not built.
// -----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byte_enable,
    input  logic [31:0]       mem_rdata
);

    localparam int AW1 = ADDR_W + 1;

    lsu_state_t          r_state;
    lsu_state_t          w_next;

    logic                r_is_store;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_fault;
    logic [31:0]         r_rdata_lo;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0]         r_rdata_hi;
`endif

    logic                w_accept;
    logic [3:0]          w_req_mask;
    logic [AW1-1:0]      w_last_byte;
    logic                w_out_of_range;
    logic                w_misaligned;
    logic                w_req_fault;
    logic [ADDR_W-1:0]   w_base;
    logic [SPAN_BYTES-1:0] w_be_span;
    logic [SPAN_W-1:0]   w_wd_span;
    logic [SPAN_W-1:0]   w_rdata_span;
    logic [31:0]         w_load_data;
    logic                w_mem_write;

    // -------------------------------------------------------------------------
    // Request acceptance and checks, evaluated on the incoming request so the
    // fault decision is already known when the request is captured.
    // -------------------------------------------------------------------------
    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_req_mask  = size_mask(req_funct3);
        // Highest touched byte = addr + size - 1; {mask[3], mask[1]} is size-1.
        // The extra top bit catches wrap past 2^ADDR_W.
        w_last_byte = {1'b0, req_addr} + AW1'({w_req_mask[3], w_req_mask[1]});
        w_out_of_range = w_last_byte[ADDR_W] ||
                         (w_last_byte[ADDR_W-1:0] >= ADDR_W'(MEM_BYTES));
`ifdef LSU_MISALIGN_SPLIT_EN
        w_misaligned = 1'b0;
`else
        w_misaligned = (w_req_mask[1] && req_addr[0]) || (w_req_mask[3] && req_addr[1]);
`endif
        w_req_fault = !funct3_legal(req_is_store, req_funct3) || w_out_of_range ||
                      w_misaligned;
    end

    // -------------------------------------------------------------------------
    // Lane steering / load extraction on the captured request.
    // -------------------------------------------------------------------------
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_rdata_span = {r_rdata_hi, r_rdata_lo};
`else
    assign w_rdata_span = r_rdata_lo;
`endif

    lsu_align u_align (
        .i_off        (r_addr[1:0]),
        .i_funct3     (r_funct3),
        .i_wdata      (r_wdata),
        .i_rdata_span (w_rdata_span),
        .o_be_span    (w_be_span),
        .o_wd_span    (w_wd_span),
        .o_load_data  (w_load_data)
    );

    assign w_base = {r_addr[ADDR_W-1:2], 2'b00};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; combinational blocks use
    // blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // -------------------------------------------------------------------------
    // FSM: next state and memory-side outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_next          = r_state;
        w_mem_write     = 1'b0;
        mem_addr        = '0;
        mem_wdata       = 32'd0;
        mem_byte_enable = 4'd0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = w_req_fault ? RESP : ACC0;
            end
            ACC0: begin
                mem_addr        = w_base;
                mem_byte_enable = w_be_span[3:0];
                mem_wdata       = w_wd_span[31:0];
                w_mem_write     = r_is_store;
`ifdef LSU_MISALIGN_SPLIT_EN
                w_next          = (|w_be_span[7:4]) ? ACC1 : RESP;
`else
                w_next          = RESP;
`endif
            end
            ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                mem_addr        = w_base + ADDR_W'(4);
                mem_byte_enable = w_be_span[7:4];
                mem_wdata       = w_wd_span[63:32];
                w_mem_write     = r_is_store;
                w_next          = RESP;
`else
                w_next          = IDLE;
`endif
            end
            RESP: begin
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A reset arriving mid-access must not let that cycle's write through.
    assign mem_write = w_mem_write && !rst;

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_fault    <= 1'b0;
        end else if (w_accept) begin
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_fault    <= w_req_fault;
        end
    end

    // Read-data holding registers. NOTE: these are pure datapath and are left
    // out of reset; the response mux below never exposes them outside RESP of
    // a completed load.
    always_ff @(posedge clk) begin
        if (r_state == ACC0 && !r_is_store) r_rdata_lo <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (r_state == ACC1 && !r_is_store) r_rdata_hi <= mem_rdata;
`endif
    end

    // -------------------------------------------------------------------------
    // Response: driven only from registers, so it is stable while stalled.
    // -------------------------------------------------------------------------
    assign resp_valid = (r_state == RESP);
    assign resp_fault = resp_valid && r_fault;
    assign resp_rdata = (resp_valid && !r_fault && !r_is_store) ? w_load_data : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
// Self-checking bench for lsu_ctrl with a byte-addressed memory behind it and
// an independent reference byte array. Expected responses are queued when a
// request is driven and popped when the response appears.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;
    logic        tb_clear;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] dmem    [1024];
    logic [7:0] ref_mem [1024];

    // Observations of the most recent request.
    logic [31:0] cyc_addr [2];
    logic [31:0] cyc_wd   [2];
    logic [3:0]  cyc_be   [2];
    int          wr_pulses;
    logic [31:0] last_rdata;
    logic        last_fault;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_fault      (resp_fault),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata)
    );

    // Data memory: combinational read, byte-enabled synchronous write.
    always_comb begin
        mem_rdata = 32'd0;
        for (int i = 0; i < 4; i++)
            if (mem_addr + 32'(i) < 32'd1024)
                mem_rdata[8*i +: 8] = dmem[mem_addr[9:0] + 10'(i)];
    end

    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 8'd0;
        end else if (mem_write) begin
            for (int i = 0; i < 4; i++)
                if (mem_byte_enable[i] && (mem_addr + 32'(i) < 32'd1024))
                    dmem[mem_addr[9:0] + 10'(i)] <= mem_wdata[8*i +: 8];
        end
    end

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        longint last;
        bit legal;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        last = longint'(a) + longint'(m_size(f3)) - 1;
        if (last >= 1024) return 1'b1;
`ifndef LSU_MISALIGN_SPLIT_EN
        if ((a % m_size(f3)) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < m_size(f3); i++) v[8*i +: 8] = ref_mem[a + 32'(i)];
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Drive one request, follow it to its response and check it against the
    // queued expectation. hold = cycles to stall resp_ready; poke = present a
    // competing store while stalled.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input bit poke,
                          input string name);
        exp_t e, got;
        int   tmo, lat, ncyc;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        e.fault = m_fault(st, f3, a);
        e.rdata = (st || e.fault) ? 32'd0 : m_load(f3, a);
        e.lat   = e.fault ? 1 : ((((a % 4) + 32'(m_size(f3))) > 4) ? 3 : 2);
        exp_q.push_back(e);
        if (st && !e.fault)
            for (int i = 0; i < m_size(f3); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        tmo = 0;
        while (!req_ready && tmo < 20) begin @(negedge clk); tmo++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; ncyc = 0; wr_pulses = 0;
        cyc_addr[0] = '0; cyc_addr[1] = '0; cyc_wd[0] = '0; cyc_wd[1] = '0;
        cyc_be[0] = '0; cyc_be[1] = '0;
        while (!resp_valid && lat < 10) begin
            if (ncyc < 2) begin
                cyc_addr[ncyc] = mem_addr; cyc_be[ncyc] = mem_byte_enable; cyc_wd[ncyc] = mem_wdata;
            end
            if (mem_write) wr_pulses++;
            ncyc++;
            @(negedge clk);
            lat++;
        end
        got = exp_q.pop_front();
        cmp_cnt++;
        if (!resp_valid) begin
            err_cnt++;
            $display("FAIL %s timeout: resp_valid never rose (waited %0d cycles)", name, lat);
            return;
        end
        last_rdata = resp_rdata; last_fault = resp_fault;
        if (resp_rdata !== got.rdata || resp_fault !== got.fault || lat != got.lat) begin
            err_cnt++;
            $display("FAIL %s resp: got rdata=%h fault=%b lat=%0d, want rdata=%h fault=%b lat=%0d",
                     name, resp_rdata, resp_fault, lat, got.rdata, got.fault, got.lat);
        end
        cmp_cnt++;
        if (req_ready !== 1'b0 || mem_write !== 1'b0 || mem_byte_enable !== 4'd0) begin
            err_cnt++;
            $display("FAIL %s resp_idle_bus: ready=%b we=%b be=%b, want 0/0/0",
                     name, req_ready, mem_write, mem_byte_enable);
        end
        for (int k = 0; k < hold; k++) begin
            if (poke) begin
                req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
                req_addr = 32'h10; req_wdata = 32'd0;
            end
            @(negedge clk);
            cmp_cnt++;
            if (resp_valid !== 1'b1 || resp_rdata !== got.rdata || req_ready !== 1'b0 ||
                mem_write !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s stall%0d: valid=%b rdata=%h ready=%b we=%b, want 1/%h/0/0",
                         name, k, resp_valid, resp_rdata, req_ready, mem_write, got.rdata);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        cmp_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s handshake: valid=%b ready=%b, want 0/1", name, resp_valid, req_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; tb_clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (req_ready !== 1'b0) begin
            err_cnt++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready);
        end
        rst = 1'b0; tb_clear = 1'b0;
        #1;
        cmp_cnt++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0 ||
            resp_rdata !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_resp: ready=%b valid=%b fault=%b rdata=%h, want 1/0/0/0",
                     req_ready, resp_valid, resp_fault, resp_rdata);
        end
        cmp_cnt++;
        if (mem_write !== 1'b0 || mem_byte_enable !== 4'd0 || mem_addr !== 32'd0 ||
            mem_wdata !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_mem: we=%b be=%b addr=%h wd=%h, want all 0",
                     mem_write, mem_byte_enable, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_sw_lw();
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, "sw_10");
        cmp_cnt++;
        if (cyc_addr[0] !== 32'h10 || cyc_be[0] !== 4'b1111 || cyc_wd[0] !== 32'hDEADBEEF ||
            wr_pulses != 1) begin
            err_cnt++;
            $display("FAIL sw_10_bus: addr=%h be=%b wd=%h writes=%0d, want 10/1111/deadbeef/1",
                     cyc_addr[0], cyc_be[0], cyc_wd[0], wr_pulses);
        end
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, 1'b0, "lw_10");
        cmp_cnt++;
        if (last_rdata !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL lw_10_value: got %h want deadbeef", last_rdata);
        end
    endtask

    task automatic test_sb_sign();
        do_req(1'b1, 3'd0, 32'h23, 32'h80, 0, 1'b0, "sb_23");
        cmp_cnt++;
        if (cyc_addr[0] !== 32'h20 || cyc_be[0] !== 4'b1000 || cyc_wd[0] !== 32'h80000000) begin
            err_cnt++;
            $display("FAIL sb_23_bus: addr=%h be=%b wd=%h, want 20/1000/80000000",
                     cyc_addr[0], cyc_be[0], cyc_wd[0]);
        end
        do_req(1'b0, 3'd0, 32'h23, 32'd0, 0, 1'b0, "lb_23");
        cmp_cnt++;
        if (last_rdata !== 32'hFFFFFF80) begin
            err_cnt++; $display("FAIL lb_23_value: got %h want ffffff80", last_rdata);
        end
        do_req(1'b0, 3'd4, 32'h23, 32'd0, 0, 1'b0, "lbu_23");
        cmp_cnt++;
        if (last_rdata !== 32'h00000080) begin
            err_cnt++; $display("FAIL lbu_23_value: got %h want 00000080", last_rdata);
        end
    endtask

    task automatic test_halfword();
        do_req(1'b1, 3'd1, 32'h32, 32'h0000BEEF, 0, 1'b0, "sh_32");
        cmp_cnt++;
        if (cyc_addr[0] !== 32'h30 || cyc_be[0] !== 4'b1100 || cyc_wd[0] !== 32'hBEEF0000) begin
            err_cnt++;
            $display("FAIL sh_32_bus: addr=%h be=%b wd=%h, want 30/1100/beef0000",
                     cyc_addr[0], cyc_be[0], cyc_wd[0]);
        end
        do_req(1'b0, 3'd1, 32'h32, 32'd0, 0, 1'b0, "lh_32");
        do_req(1'b0, 3'd5, 32'h32, 32'd0, 0, 1'b0, "lhu_32");
        cmp_cnt++;
        if (last_rdata !== 32'h0000BEEF) begin
            err_cnt++; $display("FAIL lhu_32_value: got %h want 0000beef", last_rdata);
        end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_SPLIT_EN
        do_req(1'b1, 3'd2, 32'h42, 32'h11223344, 0, 1'b0, "sw_42_split");
        cmp_cnt++;
        if (cyc_addr[0] !== 32'h40 || cyc_be[0] !== 4'b1100 || cyc_wd[0] !== 32'h33440000 ||
            cyc_addr[1] !== 32'h44 || cyc_be[1] !== 4'b0011 || cyc_wd[1] !== 32'h00001122 ||
            wr_pulses != 2) begin
            err_cnt++;
            $display("FAIL sw_42_split_bus: %h/%b/%h then %h/%b/%h writes=%0d, want 40/1100/33440000 then 44/0011/00001122 writes=2",
                     cyc_addr[0], cyc_be[0], cyc_wd[0], cyc_addr[1], cyc_be[1], cyc_wd[1], wr_pulses);
        end
        do_req(1'b0, 3'd2, 32'h42, 32'd0, 0, 1'b0, "lw_42_split");
        cmp_cnt++;
        if (last_rdata !== 32'h11223344) begin
            err_cnt++; $display("FAIL lw_42_value: got %h want 11223344", last_rdata);
        end
`else
        do_req(1'b1, 3'd2, 32'h42, 32'h11223344, 0, 1'b0, "sw_42_fault");
        cmp_cnt++;
        if (last_fault !== 1'b1 || wr_pulses != 0) begin
            err_cnt++;
            $display("FAIL sw_42_nowrite: fault=%b writes=%0d, want 1/0", last_fault, wr_pulses);
        end
        do_req(1'b0, 3'd1, 32'h21, 32'd0, 0, 1'b0, "lh_21_fault");
`endif
    endtask

    task automatic test_faults();
        do_req(1'b0, 3'd2, 32'd1022, 32'd0, 0, 1'b0, "lw_1022");
        cmp_cnt++;
        if (last_fault !== 1'b1) begin
            err_cnt++; $display("FAIL lw_1022_fault: got %b want 1", last_fault);
        end
        do_req(1'b0, 3'd3, 32'h10, 32'd0, 0, 1'b0, "ld_f3_011");
        do_req(1'b1, 3'd4, 32'h10, 32'd0, 0, 1'b0, "st_f3_100");
        do_req(1'b1, 3'd1, 32'd1023, 32'hFFFF, 0, 1'b0, "sh_1023");
        cmp_cnt++;
        if (wr_pulses != 0) begin
            err_cnt++; $display("FAIL sh_1023_nowrite: got %0d writes want 0", wr_pulses);
        end
        do_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, 0, 1'b0, "lw_wrap");
        do_req(1'b1, 3'd2, 32'd1020, 32'hCAFEF00D, 0, 1'b0, "sw_1020");
        cmp_cnt++;
        if (last_fault !== 1'b0 || wr_pulses != 1 || cyc_addr[0] !== 32'd1020) begin
            err_cnt++;
            $display("FAIL sw_1020_legal: fault=%b writes=%0d addr=%h, want 0/1/3fc",
                     last_fault, wr_pulses, cyc_addr[0]);
        end
        do_req(1'b0, 3'd2, 32'd1020, 32'd0, 0, 1'b0, "lw_1020");
        do_req(1'b0, 3'd0, 32'd1023, 32'd0, 0, 1'b0, "lb_1023");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h10; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cmp_cnt++;
        if (mem_write !== 1'b1) begin
            err_cnt++; $display("FAIL rstmid_acc0_we: got %b want 1", mem_write);
        end
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if (mem_write !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_gate: mem_write got %b want 0", mem_write);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp_cnt++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_idle: ready=%b valid=%b want 1/0", req_ready, resp_valid);
        end
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, 1'b0, "rstmid_readback");
        cmp_cnt++;
        if (last_rdata !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL rstmid_old_value: got %h want deadbeef", last_rdata);
        end
    endtask

    task automatic test_stall();
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 3, 1'b1, "stall_lw_10");
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, 1'b0, "stall_after");
        cmp_cnt++;
        if (last_rdata !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL stall_ignored_req: got %h want deadbeef", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [7];
        codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        for (int n = 0; n < 40; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = codes[$urandom_range(0, 6)];
            a  = (n < 20) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 1030));
            do_req(st, f3, a, $urandom, 0, 1'b0, "rand");
        end
    endtask

    initial begin
        rst = 1'b1; tb_clear = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
        test_reset();
        test_sw_lw();
        test_sb_sign();
        test_halfword();
        test_misalign();
        test_faults();
        test_reset_mid();
        test_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
